// File: rtl/alu_pkg.sv
// ALU-side shared definitions: op encoding used by operand fetch, ALU and benches.
// No logic; no latency.
// No flow control.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    localparam int ALU_OP_W = 2;

endpackage

// File: rtl/alu_regfile.sv
// 2-read/1-write register file, x0 hard-wired to zero, asynchronous reads.
// Write lands at the clock edge; reads are combinational (0 cycles).
// No flow control: writes are always taken.
module alu_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_dat_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_dat_b
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_dat_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand fetch ahead of the ALU: regfile read with writeback bypass, RAW scoreboard.
// One registered stage: accept -> out_valid after 1 cycle, 1 instruction/clk sustained.
// in_ready drops on a full slot that is not draining, or on a pending source register.
module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_use_imm,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_rs1,
    output logic [DATA_WIDTH-1:0] source_2,
    output logic [1:0]            alu_inst,
    output logic [ADDR_WIDTH-1:0] out_rd,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    localparam int NREG = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs1_dat;
        logic [DATA_WIDTH-1:0] src2_dat;
        alu_op_t               op;
        logic [ADDR_WIDTH-1:0] rd;
    } slot_t;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

    slot_state_t           state, state_nxt;
    slot_t                 slot;
    logic [NREG-1:0]       pend, pend_nxt;
    logic [DATA_WIDTH-1:0] rf_dat_a, rf_dat_b, op1_dat, op2_dat;
    logic                  byp_a, byp_b, haz_a, haz_b, hazard, accept;

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wb_en),
        .wr_addr   (wb_rd),
        .wr_dat    (wb_data),
        .rd_addr_a (in_rs1),
        .rd_dat_a  (rf_dat_a),
        .rd_addr_b (in_rs2),
        .rd_dat_b  (rf_dat_b)
    );

    // A writeback landing this cycle both forwards its data and resolves the hazard.
    assign byp_a   = wb_en && (wb_rd == in_rs1) && (in_rs1 != '0);
    assign byp_b   = wb_en && (wb_rd == in_rs2) && (in_rs2 != '0);
    assign op1_dat = byp_a ? wb_data : rf_dat_a;
    assign op2_dat = in_use_imm ? in_imm : (byp_b ? wb_data : rf_dat_b);

    assign haz_a   = pend[in_rs1] && !byp_a;
    assign haz_b   = pend[in_rs2] && !byp_b && !in_use_imm;
    assign hazard  = haz_a || haz_b;

    assign out_valid = (state == SLOT_FULL);
    assign in_ready  = (!out_valid || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;

    // Set after clear so an issue targeting the register being written back stays pending.
    always_comb begin
        pend_nxt = pend;
        if (wb_en) begin
            pend_nxt[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            pend_nxt[in_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (accept) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !accept) state_nxt = SLOT_EMPTY;
            default:    state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            pend  <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            if (accept) begin
                slot <= '{rs1_dat: op1_dat, src2_dat: op2_dat, op: alu_op_t'(in_op), rd: in_rd};
            end
        end
    end

    assign data_rs1 = slot.rs1_dat;
    assign source_2 = slot.src2_dat;
    assign alu_inst = slot.op;
    assign out_rd   = slot.rd;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomised + directed bench for alu_operand_fetch with a queue-based scoreboard.
// The reference keeps architectural register values and a pending-destination set.
module tb_alu_operand_fetch;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_use_imm, out_valid, out_ready, wb_en;
    logic [1:0]    in_op, alu_inst;
    logic [AW-1:0] in_rs1, in_rs2, in_rd, out_rd, wb_rd;
    logic [DW-1:0] in_imm, data_rs1, source_2, wb_data;

    always #5 clk = ~clk;

    alu_operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_rs1   (data_rs1),
        .source_2   (source_2),
        .alu_inst   (alu_inst),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_rf [8];
    bit            m_pend [8];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_rf[i]   = '0;
            m_pend[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Architectural value of a source as seen this cycle (writeback in flight is visible).
    function automatic logic [DW-1:0] src_val(input logic [AW-1:0] r, input bit we,
                                              input logic [AW-1:0] wr, input logic [DW-1:0] wd);
        if (r == 0) return '0;
        if (we && wr == r) return wd;
        return m_rf[r];
    endfunction

    function automatic bit src_busy(input logic [AW-1:0] r, input bit we, input logic [AW-1:0] wr);
        return (r != 0) && m_pend[r] && !(we && wr == r);
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input bit v, input logic [1:0] op, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input logic [AW-1:0] rd, input bit ui,
                        input logic [DW-1:0] imm, input bit ordy, input bit we,
                        input logic [AW-1:0] wrd, input logic [DW-1:0] wd);
        bit   exp_rdy, acc;
        exp_t e;
        in_valid = v; in_op = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
        in_use_imm = ui; in_imm = imm; out_ready = ordy;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        #1;
        exp_rdy = (exp_q.size() == 0 || ordy) &&
                  !(src_busy(r1, we, wrd) || (!ui && src_busy(r2, we, wrd)));
        chk("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        e.a  = src_val(r1, we, wrd, wd);
        e.b  = ui ? imm : src_val(r2, we, wrd, wd);
        e.op = op;
        e.rd = rd;
        @(posedge clk);
        if (acc) exp_q.push_back(e);
        if (we) begin
            if (wrd != 0) m_rf[wrd] = wd;
            m_pend[wrd] = 1'b0;
        end
        if (acc && rd != 0) m_pend[rd] = 1'b1;
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 2'b00, 0, 0, 0, 1, 8'h00, ordy, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        wb_en    = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_rs1", data_rs1, 0);
        chk("rst_source_2", source_2, 0);
        chk("rst_alu_inst", alu_inst, 0);
        chk("rst_out_rd", out_rd, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: the slot must hold exactly the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("data_rs1", data_rs1, exp_q[0].a);
                chk("source_2", source_2, exp_q[0].b);
                chk("alu_inst", alu_inst, exp_q[0].op);
                chk("out_rd", out_rd, exp_q[0].rd);
            end
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_imm = 0; in_imm = 0; out_ready = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        #1;
        do_reset();

        // Write r3=5, then ADD rs1=3, imm=5, rd=4.
        step(0, 2'b00, 0, 0, 0, 0, 8'h00, 1, 1, 3, 8'h05);
        step(1, 2'b00, 3, 0, 4, 1, 8'h05, 1, 0, 0, 8'h00);
        idle(1);

        // RAW: rd=2 issued, consumer of r2 stalls until writeback of 9 bypasses in.
        step(1, 2'b01, 0, 0, 2, 1, 8'h11, 1, 0, 0, 8'h00);
        step(1, 2'b10, 2, 0, 0, 1, 8'h22, 1, 0, 0, 8'h00);
        step(1, 2'b10, 2, 0, 0, 1, 8'h22, 1, 0, 0, 8'h00);
        step(1, 2'b10, 2, 0, 0, 1, 8'h22, 1, 1, 2, 8'h09);
        idle(1);

        // Backpressure: slot held for 3 cycles, then back-to-back issue.
        step(1, 2'b11, 3, 0, 0, 1, 8'h40, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 2'b00, 3, 0, 0, 1, 8'h41, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 2'(i), 3, 4, 0, 1, 8'(8'h50 + i), 1, 0, 0, 8'h00);
        idle(1);

        // x0: write ignored, reads zero, rd=0 never pends.
        step(0, 2'b00, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h07);
        step(1, 2'b00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        step(1, 2'b01, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        idle(1);

        // Set/clear collision on r5: the new issue keeps r5 pending.
        step(1, 2'b00, 0, 0, 5, 1, 8'h01, 1, 1, 5, 8'h33);
        step(1, 2'b00, 5, 0, 0, 1, 8'h02, 1, 0, 0, 8'h00);
        step(1, 2'b00, 5, 0, 0, 1, 8'h02, 1, 1, 5, 8'h44);
        idle(1);

        // Reset with an instruction held in the slot; r1 reads 0 afterwards.
        step(0, 2'b00, 0, 0, 0, 0, 8'h00, 0, 1, 1, 8'hAA);
        step(1, 2'b00, 1, 0, 6, 1, 8'h03, 0, 0, 0, 8'h00);
        do_reset();
        step(1, 2'b00, 1, 6, 7, 0, 8'h00, 1, 0, 0, 8'h00);
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] wrd;
            int            busy[$];
            for (int r = 1; r < 8; r++) if (m_pend[r]) busy.push_back(r);
            wrd = AW'($urandom_range(0, 7));
            if (busy.size() != 0 && $urandom_range(0, 3) != 0)
                wrd = AW'(busy[$urandom_range(0, busy.size() - 1)]);
            step($urandom_range(0, 9) < 7, 2'($urandom), AW'($urandom), AW'($urandom),
                 AW'($urandom), $urandom_range(0, 9) < 3, 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, wrd, 8'($urandom));
        end
        for (int i = 0; i < 3; i++) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
